ddr_rw_arbiter: RTL

DDR_RW_ARBITER -- requirements
Module: ddr_rw_arbiter

---
 rtl/ddr_arb_pkg.sv | 35 +++
 rtl/ddr_rw_arbiter_if.sv | 47 ++++
 rtl/arb_req_latch.sv | 46 ++++
 rtl/ddr_rw_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared encodings and default sizes for the DDR read/write arbiter.
// Contains the FSM states, the owner codes and the round-robin pick helper.
package ddr_arb_pkg;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_LEN_W   = 16;
  localparam int DEF_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_WR = 1'b0,
    OWN_RD = 1'b1
  } owner_e;

  // A lone requester always wins; on contention the one that was not served last wins.
  function automatic owner_e rr_pick(input logic wr_pend, input logic rd_pend,
                                     input owner_e last_owner);
    owner_e pick;
    if (wr_pend && rd_pend) begin
      pick = (last_owner == OWN_WR) ? OWN_RD : OWN_WR;
    end else if (rd_pend) begin
      pick = OWN_RD;
    end else begin
      pick = OWN_WR;
    end
    return pick;
  endfunction

endpackage

// File: rtl/ddr_rw_arbiter_if.sv
// Requester, burst-engine command and status signals of the DDR read/write arbiter.
// slave = arbiter side, master = requesters plus burst engine side.
interface ddr_rw_arbiter_if
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [LEN_W-1:0]  wr_length;
  logic              wr_busy;
  logic              wr_done;

  logic              rd_req;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [LEN_W-1:0]  rd_length;
  logic              rd_busy;
  logic              rd_done;

  logic              cmd_req;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              eng_done;
  logic              timeout_err;

  modport slave (
    input  wr_req, wr_req_addr, wr_length,
    input  rd_req, rd_req_addr, rd_length,
    input  eng_done,
    output wr_busy, wr_done, rd_busy, rd_done,
    output cmd_req, cmd_write, cmd_addr, cmd_len,
    output timeout_err
  );

  modport master (
    output wr_req, wr_req_addr, wr_length,
    output rd_req, rd_req_addr, rd_length,
    output eng_done,
    input  wr_busy, wr_done, rd_busy, rd_done,
    input  cmd_req, cmd_write, cmd_addr, cmd_len,
    input  timeout_err
  );

endinterface

// File: rtl/arb_req_latch.sv
// Pending-request capture for one requester: holds address and length until cleared.
// A request in the clearing cycle is kept, so back-to-back requests are never lost.
module arb_req_latch
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_clr,
  output logic              o_pend,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]  o_len
);

  logic              r_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              w_capture;

  // A pulse is dropped while pending, unless the pending entry retires this same cycle.
  assign w_capture = i_set && (!r_pend || i_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
      r_addr <= {ADDR_W{1'b0}};
      r_len  <= {LEN_W{1'b0}};
    end else if (w_capture) begin
      r_pend <= 1'b1;
      r_addr <= i_addr;
      r_len  <= i_len;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_addr = r_addr;
  assign o_len  = r_len;

endmodule

// File: rtl/ddr_rw_arbiter.sv
// Shares one DDR burst engine between a write and a read requester, with a watchdog.
// Define ARB_RD_PRIORITY_EN for fixed read priority; otherwise contention is round-robin.
module ddr_rw_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst_n,
  ddr_rw_arbiter_if.slave bus
);

  localparam int                WDOG_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(TIMEOUT - 1);

  logic              w_wr_pend, w_rd_pend;
  logic [ADDR_W-1:0] w_wr_addr, w_rd_addr;
  logic [LEN_W-1:0]  w_wr_len, w_rd_len;
  logic              w_wr_clr, w_rd_clr;
  logic              w_wdog_hit;
  logic              w_grant_en;
  owner_e            w_grant;
  arb_state_e        w_state_nxt;

  arb_state_e        r_state;
  owner_e            r_owner;
  logic              r_cmd_req, r_cmd_write;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [LEN_W-1:0]  r_cmd_len;
  logic              r_wr_busy, r_rd_busy, r_wr_done, r_rd_done;
  logic              r_timeout_err;
  logic [WDOG_W-1:0] r_wdog;

  assign w_wr_clr   = (r_state == ST_DONE) && (r_owner == OWN_WR);
  assign w_rd_clr   = (r_state == ST_DONE) && (r_owner == OWN_RD);
  assign w_wdog_hit = (r_state == ST_WAIT) && (r_wdog == WDOG_MAX);
  assign w_grant_en = (r_state == ST_IDLE) && (w_state_nxt == ST_ISSUE);

  arb_req_latch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_latch (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_set  (bus.wr_req),
    .i_addr (bus.wr_req_addr),
    .i_len  (bus.wr_length),
    .i_clr  (w_wr_clr),
    .o_pend (w_wr_pend),
    .o_addr (w_wr_addr),
    .o_len  (w_wr_len)
  );

  arb_req_latch #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_latch (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_set  (bus.rd_req),
    .i_addr (bus.rd_req_addr),
    .i_len  (bus.rd_length),
    .i_clr  (w_rd_clr),
    .o_pend (w_rd_pend),
    .o_addr (w_rd_addr),
    .o_len  (w_rd_len)
  );

`ifdef ARB_RD_PRIORITY_EN
  assign w_grant = w_rd_pend ? OWN_RD : OWN_WR;
`else
  owner_e r_last_owner;

  assign w_grant = rr_pick(w_wr_pend, w_rd_pend, r_last_owner);

  // Starts as write so the first contended grant goes to read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= OWN_WR;
    end else if (r_state == ST_DONE) begin
      r_last_owner <= r_owner;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_pend || w_rd_pend) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus.eng_done || w_wdog_hit) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Command fields are loaded at grant and held untouched through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_WR;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= {ADDR_W{1'b0}};
      r_cmd_len   <= {LEN_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_en) begin
        r_owner     <= w_grant;
        r_cmd_write <= (w_grant == OWN_WR);
        r_cmd_addr  <= (w_grant == OWN_WR) ? w_wr_addr : w_rd_addr;
        r_cmd_len   <= (w_grant == OWN_WR) ? w_wr_len : w_rd_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_req <= 1'b0;
      r_wr_done <= 1'b0;
      r_rd_done <= 1'b0;
      r_wr_busy <= 1'b0;
      r_rd_busy <= 1'b0;
    end else begin
      r_cmd_req <= (w_state_nxt == ST_ISSUE);
      r_wr_done <= w_wr_clr;
      r_rd_done <= w_rd_clr;
      r_wr_busy <= w_wr_pend;
      r_rd_busy <= w_rd_pend;
    end
  end

  // Watchdog counts WAIT cycles only; timeout_err is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog        <= {WDOG_W{1'b0}};
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_WAIT)) begin
        r_wdog <= r_wdog + WDOG_W'(1'b1);
      end else begin
        r_wdog <= {WDOG_W{1'b0}};
      end
      if (w_wdog_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.cmd_req     = r_cmd_req;
  assign bus.cmd_write   = r_cmd_write;
  assign bus.cmd_addr    = r_cmd_addr;
  assign bus.cmd_len     = r_cmd_len;
  assign bus.wr_busy     = r_wr_busy;
  assign bus.wr_done     = r_wr_done;
  assign bus.rd_busy     = r_rd_busy;
  assign bus.rd_done     = r_rd_done;
  assign bus.timeout_err = r_timeout_err;

endmodule
